// File: rtl/lpddr2_frame_pkg.sv
// ----------------------------------------------------------------------------
// lpddr2_frame_pkg
// Shared types and helpers for the LPDDR2 frame writer.
//   state_t      : capture/write FSM states
//   frame_words  : number of words (pixels) in one frame
//   PIX_PAD      : filler byte placed above the 24-bit pixel in each word
// ----------------------------------------------------------------------------
package lpddr2_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [7:0] PIX_PAD = 8'h00;

    function automatic int unsigned frame_words(input int unsigned h, input int unsigned v);
        return h * v;
    endfunction

endpackage

// File: rtl/lpddr2_frame_writer_fifo.sv
// ----------------------------------------------------------------------------
// frame_wr_fifo
// Synchronous show-ahead FIFO: the head entry is visible on pop_data whenever
// empty is low; pop consumes it at the clock edge.
// The caller gates push with full; a push while full is legal only together
// with a pop, in which case the freed slot is reused in the same edge.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   push, push_data    : write strobe and entry
//   pop                : consume head entry (only while not empty)
//   pop_data           : head entry
//   full, empty        : occupancy flags
// ----------------------------------------------------------------------------
module frame_wr_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers define which entries
    // are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/lpddr2_frame_writer.sv
// ----------------------------------------------------------------------------
// lpddr2_frame_writer
// Avalon-MM write master that stores one captured frame into LPDDR2 as
// single-word writes (burstcount 1), starting at BASE_ADDR.
// Optional feature macro: FRAME_WR_CHECKSUM_EN (running sum of accepted
// writedata on 'checksum'; tied to 0 when undefined).
// Ports:
//   clk, reset            : afi_half_clk, asynchronous active-high reset
//   start                 : one-cycle arm pulse (honoured in IDLE/DONE only)
//   pix_valid, pix_sof    : pixel strobe, first-pixel-of-frame qualifier
//   pix_data              : RGB888 pixel
//   avl_waitrequest_n     : controller ready
//   avl_address           : word address of the presented command
//   avl_writedata         : {8'h00, pixel}
//   avl_write             : write request
//   avl_burstbegin        : first cycle of each command
//   busy, done            : armed/writing, frame committed
//   overflow, sync_err    : sticky dropped-pixel / unexpected-SOF flags
//   checksum              : running word sum (optional)
// ----------------------------------------------------------------------------
module lpddr2_frame_writer
    import lpddr2_frame_pkg::*;
#(
    parameter int                ADDR_W     = 27,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                H_ACTIVE   = 1920,
    parameter int                V_ACTIVE   = 1080,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [23:0]       pix_data,
    input  logic              avl_waitrequest_n,
    output logic [ADDR_W-1:0] avl_address,
    output logic [31:0]       avl_writedata,
    output logic              avl_write,
    output logic              avl_burstbegin,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              sync_err,
    output logic [31:0]       checksum
);

    localparam int unsigned TOTAL = frame_words(H_ACTIVE, V_ACTIVE);
    localparam int          IDX_W = $clog2(TOTAL + 1);
    localparam int          ENT_W = 24 + IDX_W;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] pix_cnt;
    logic             last_pix;
    logic             arm;
    logic             pix_take;
    logic             sof_in_capture;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] fifo_head;
    logic             accept;
    logic             drop;

    // Each entry carries its pixel index so that dropped pixels leave holes
    // in the address map instead of shifting later pixels down.
    frame_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({pix_cnt, pix_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign last_pix  = (pix_cnt == IDX_W'(TOTAL - 1));
    assign accept    = avl_write & avl_waitrequest_n;
    // A pending command frees its slot in the cycle it is accepted, so the
    // next entry can be loaded back-to-back.
    assign fifo_pop  = !fifo_empty && (!avl_write || avl_waitrequest_n);
    assign fifo_push = pix_take && (!fifo_full || fifo_pop);
    assign drop      = pix_take && fifo_full && !fifo_pop;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_next = state;
        unique case (state)
            ST_IDLE:     if (start) state_next = ST_WAIT_SOF;
            ST_WAIT_SOF: if (pix_valid && pix_sof)
                             state_next = last_pix ? ST_DRAIN : ST_CAPTURE;
            ST_CAPTURE:  if (pix_valid && last_pix) state_next = ST_DRAIN;
            ST_DRAIN:    if (fifo_empty && (!avl_write || avl_waitrequest_n))
                             state_next = ST_DONE;
            ST_DONE:     if (start) state_next = ST_WAIT_SOF;
            default:     state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        arm            = 1'b0;
        pix_take       = 1'b0;
        sof_in_capture = 1'b0;
        unique case (state)
            ST_IDLE:     arm = start;
            ST_WAIT_SOF: begin
                busy     = 1'b1;
                pix_take = pix_valid && pix_sof;
            end
            ST_CAPTURE:  begin
                busy           = 1'b1;
                pix_take       = pix_valid;
                sof_in_capture = pix_valid && pix_sof;
            end
            ST_DRAIN:    busy = 1'b1;
            ST_DONE:     begin
                done = 1'b1;
                arm  = start;
            end
            default:     ;
        endcase
    end

    // ---------------- pixel counter and sticky flags ----------------
    // The counter advances on dropped pixels too, keeping indices frame-aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt  <= '0;
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else if (arm) begin
            pix_cnt  <= '0;
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (pix_take)       pix_cnt  <= pix_cnt + 1'b1;
            if (drop)           overflow <= 1'b1;
            if (sof_in_capture) sync_err <= 1'b1;
        end
    end

    // ---------------- Avalon command register ----------------
    // Address/data only change when a new entry is loaded, so they stay
    // stable for as long as the controller stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avl_write      <= 1'b0;
            avl_burstbegin <= 1'b0;
            avl_address    <= '0;
            avl_writedata  <= '0;
        end else begin
            avl_burstbegin <= fifo_pop;
            if (fifo_pop) begin
                avl_write     <= 1'b1;
                avl_address   <= BASE_ADDR + ADDR_W'(fifo_head[24 +: IDX_W]);
                avl_writedata <= {PIX_PAD, fifo_head[23:0]};
            end else if (accept) begin
                avl_write     <= 1'b0;
            end
        end
    end

    // ---------------- optional checksum ----------------
`ifdef FRAME_WR_CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       sum <= '0;
        else if (arm)    sum <= '0;
        else if (accept) sum <= sum + avl_writedata;
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule
